// File: rtl/chess_move_entry_if.sv
// Board-side signal bundle for the chess move entry stage: switches and buttons in,
// captured digits, verify strobe, phase and reject out.
interface chess_move_entry_if;
   // There is no valid/ready handshake: buttons and switches are raw asynchronous levels.
   // verify is an active-low strobe that the consumer samples on its falling edge, and
   // reject is a one-cycle pulse that no consumer can stall.
   logic [3:0] sw;
   logic       key_enter_n;
   logic       key_clear_n;
   logic [3:0] user_digit1;
   logic [3:0] user_digit2;
   logic       verify;
   logic [1:0] entry_phase;
   logic       reject;

   modport master (
      output sw, key_enter_n, key_clear_n,
      input  user_digit1, user_digit2, verify, entry_phase, reject
   );

   modport slave (
      input  sw, key_enter_n, key_clear_n,
      output user_digit1, user_digit2, verify, entry_phase, reject
   );
endinterface

// File: rtl/chess_move_entry.sv
// Debounces the enter/clear buttons, captures a two-digit move from the switches,
// and issues the active-low verify strobe used by the puzzle checker.
module chess_move_entry #(
   parameter int         DEBOUNCE_CYCLES = 500000,
   parameter int         PULSE_CYCLES    = 4,
   parameter logic [3:0] MAX_DIGIT       = 4'd15
) (
   input  logic               clk,
   input  logic               rst_n,
   chess_move_entry_if.slave  bus
);

   localparam int              CW       = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]      PCNT_LAST = 8'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      WAIT1    = 2'b00,
      WAIT2    = 2'b01,
      READY    = 2'b10,
      FEEDBACK = 2'b11
   } phase_e;

   // Index 0 is the enter button, index 1 the clear button.
   logic [1:0]         key_s1_q, key_s1_d;
   logic [1:0]         key_s2_q, key_s2_d;
   logic [1:0]         key_db_q, key_db_d;
   logic [1:0][CW-1:0] key_cnt_q, key_cnt_d;
   logic [1:0]         key_ev_q, key_ev_d;
   logic [3:0]         sw_s1_q, sw_s1_d;
   logic [3:0]         sw_s2_q, sw_s2_d;

   phase_e             phase_q, phase_d;
   logic [3:0]         digit1_q, digit1_d;
   logic [3:0]         digit2_q, digit2_d;
   logic               verify_q, verify_d;
   logic [7:0]         pcnt_q, pcnt_d;
   logic               exit_q, exit_d;
   logic               reject_q, reject_d;

   logic               busy;
   logic               enter_ev;
   logic               clear_ev;
   logic               sw_ok;

   always_comb begin
      key_s1_d = {bus.key_clear_n, bus.key_enter_n};
      key_s2_d = key_s1_q;
      sw_s1_d  = bus.sw;
      sw_s2_d  = sw_s1_q;
      key_db_d  = key_db_q;
      key_cnt_d = '0;
      key_ev_d  = '0;
      // A level is accepted only after DEBOUNCE_CYCLES contrary samples in a row.
      for (int i = 0; i < 2; i++) begin
         if (key_s2_q[i] != key_db_q[i]) begin
            if (key_cnt_q[i] == DB_LAST) begin
               key_db_d[i] = key_s2_q[i];
            end else begin
               key_cnt_d[i] = key_cnt_q[i] + CW'(1);
            end
         end
         key_ev_d[i] = key_db_q[i] & ~key_db_d[i];
      end
   end

   assign busy     = ~verify_q;
   assign enter_ev = key_ev_q[0] & ~busy;
   assign clear_ev = key_ev_q[1] & ~busy;
   assign sw_ok    = ({1'b0, sw_s2_q} <= {1'b0, MAX_DIGIT});

   always_comb begin
      phase_d  = phase_q;
      digit1_d = digit1_q;
      digit2_d = digit2_q;
      verify_d = verify_q;
      pcnt_d   = pcnt_q;
      exit_d   = exit_q;
      reject_d = 1'b0;
      if (busy) begin
         if (pcnt_q == 8'd0) begin
            verify_d = 1'b1;
            exit_d   = 1'b0;
            // The second strobe in feedback hands control to the next puzzle.
            if (exit_q) begin
               digit1_d = 4'd0;
               digit2_d = 4'd0;
               phase_d  = WAIT1;
            end
         end else begin
            pcnt_d = pcnt_q - 8'd1;
         end
      end else if (clear_ev && (phase_q != FEEDBACK)) begin
         digit1_d = 4'd0;
         digit2_d = 4'd0;
         phase_d  = WAIT1;
      end else if (enter_ev) begin
         case (phase_q)
            WAIT1: begin
               if (sw_ok) begin
                  digit1_d = sw_s2_q;
                  phase_d  = WAIT2;
               end else begin
                  reject_d = 1'b1;
               end
            end
            WAIT2: begin
               if (sw_ok) begin
                  digit2_d = sw_s2_q;
                  phase_d  = READY;
               end else begin
                  reject_d = 1'b1;
               end
            end
            READY: begin
               verify_d = 1'b0;
               pcnt_d   = PCNT_LAST;
               exit_d   = 1'b0;
               phase_d  = FEEDBACK;
            end
            default: begin
               verify_d = 1'b0;
               pcnt_d   = PCNT_LAST;
               exit_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q  <= 2'b11;
         key_s2_q  <= 2'b11;
         key_db_q  <= 2'b11;
         key_cnt_q <= '0;
         key_ev_q  <= 2'b00;
         sw_s1_q   <= 4'd0;
         sw_s2_q   <= 4'd0;
         phase_q   <= WAIT1;
         digit1_q  <= 4'd0;
         digit2_q  <= 4'd0;
         verify_q  <= 1'b1;
         pcnt_q    <= 8'd0;
         exit_q    <= 1'b0;
         reject_q  <= 1'b0;
      end else begin
         key_s1_q  <= key_s1_d;
         key_s2_q  <= key_s2_d;
         key_db_q  <= key_db_d;
         key_cnt_q <= key_cnt_d;
         key_ev_q  <= key_ev_d;
         sw_s1_q   <= sw_s1_d;
         sw_s2_q   <= sw_s2_d;
         phase_q   <= phase_d;
         digit1_q  <= digit1_d;
         digit2_q  <= digit2_d;
         verify_q  <= verify_d;
         pcnt_q    <= pcnt_d;
         exit_q    <= exit_d;
         reject_q  <= reject_d;
      end
   end

   assign bus.user_digit1 = digit1_q;
   assign bus.user_digit2 = digit2_q;
   assign bus.verify      = verify_q;
   assign bus.entry_phase = phase_q;
   assign bus.reject      = reject_q;

endmodule

// File: tb/tb_chess_move_entry.sv
// Bench for chess_move_entry with DEBOUNCE_CYCLES = 4 and PULSE_CYCLES = 3.
module tb_chess_move_entry;

   typedef struct {
      logic [3:0] sw;
      logic       ent;
      logic       clr;
      logic [1:0] phase;
      logic [3:0] d1;
      logic [3:0] d2;
      int         strobes;
   } vec_t;

   logic clk;
   logic rst_n;

   chess_move_entry_if bus ();
   chess_move_entry_if bus_r ();

   chess_move_entry #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .MAX_DIGIT(4'd15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   chess_move_entry #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .MAX_DIGIT(4'd8)) dut_r (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_r)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         tests;
   int         failed;
   logic [9:0] exp_q[$];
   logic [9:0] model_obs;
   bit         exp_exit;
   int         strobes;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard / strobe monitor, sampled on the falling edge
   logic [9:0] prev_obs;
   logic [7:0] last_dig;
   logic [7:0] strobe_dig;
   logic       dig_chg;
   int         lowcnt;

   always @(negedge clk) begin
      logic [9:0] obs;
      obs = {bus.entry_phase, bus.user_digit1, bus.user_digit2};
      if (!rst_n) begin
         lowcnt   = 0;
         prev_obs = obs;
      end else begin
         if (obs !== prev_obs) begin
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL sb_unexpected: got %0h, no change expected", obs);
            end else begin
               check("sb_obs", obs, exp_q.pop_front());
            end
            prev_obs = obs;
         end
         if (!bus.verify) begin
            if (lowcnt == 0) begin
               strobe_dig = obs[7:0];
               dig_chg    = (obs[7:0] !== last_dig);
            end else if (obs[7:0] !== strobe_dig) begin
               dig_chg = 1'b1;
            end
            lowcnt++;
         end else if (lowcnt != 0) begin
            check("strobe_len", lowcnt, 3);
            check("strobe_digits_stable", dig_chg, 0);
            check("strobe_end_phase", bus.entry_phase, exp_exit ? 2'b00 : 2'b11);
            if (exp_exit) check("strobe_end_digits", obs[7:0], 0);
            strobes++;
            lowcnt = 0;
         end
      end
      last_dig = obs[7:0];
   end

   // driver: one press (enter, clear or both), held then released, then compared
   task automatic apply(input vec_t v, input string tag);
      int         s0;
      logic [9:0] e;
      s0       = strobes;
      exp_exit = (model_obs[9:8] == 2'b11) && v.ent;
      e        = {v.phase, v.d1, v.d2};
      if (e != model_obs) exp_q.push_back(e);
      model_obs = e;
      bus.sw          = v.sw;
      bus.key_enter_n = ~v.ent;
      bus.key_clear_n = ~v.clr;
      repeat (10) tick();
      bus.key_enter_n = 1'b1;
      bus.key_clear_n = 1'b1;
      repeat (12) tick();
      check({tag, "_phase"}, bus.entry_phase, v.phase);
      check({tag, "_d1"}, bus.user_digit1, v.d1);
      check({tag, "_d2"}, bus.user_digit2, v.d2);
      check({tag, "_strobes"}, strobes - s0, v.strobes);
   endtask

   task automatic press_r(input logic [3:0] s, output int rej);
      rej         = 0;
      bus_r.sw    = s;
      bus_r.key_enter_n = 1'b0;
      repeat (10) begin
         tick();
         if (bus_r.reject) rej++;
      end
      bus_r.key_enter_n = 1'b1;
      repeat (12) begin
         tick();
         if (bus_r.reject) rej++;
      end
   endtask

   vec_t tbl[15];

   initial begin
      int rej;
      logic [3:0] a;
      logic [3:0] b;
      int s0;
      int lows[3];

      tests = 0; failed = 0; strobes = 0; model_obs = '0; exp_exit = 1'b0;
      rst_n = 1'b0;
      bus.sw = 4'd0; bus.key_enter_n = 1'b1; bus.key_clear_n = 1'b1;
      bus_r.sw = 4'd0; bus_r.key_enter_n = 1'b1; bus_r.key_clear_n = 1'b1;

      tbl[0]  = '{4'hA, 1'b1, 1'b0, 2'b01, 4'hA, 4'h0, 0};
      tbl[1]  = '{4'h4, 1'b1, 1'b0, 2'b10, 4'hA, 4'h4, 0};
      tbl[2]  = '{4'h0, 1'b1, 1'b0, 2'b11, 4'hA, 4'h4, 1};
      tbl[3]  = '{4'h0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1};
      tbl[4]  = '{4'h3, 1'b1, 1'b0, 2'b01, 4'h3, 4'h0, 0};
      tbl[5]  = '{4'h0, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 0};
      tbl[6]  = '{4'h7, 1'b1, 1'b0, 2'b01, 4'h7, 4'h0, 0};
      tbl[7]  = '{4'h2, 1'b1, 1'b0, 2'b10, 4'h7, 4'h2, 0};
      tbl[8]  = '{4'h0, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 0};
      tbl[9]  = '{4'h5, 1'b1, 1'b0, 2'b01, 4'h5, 4'h0, 0};
      tbl[10] = '{4'hF, 1'b1, 1'b0, 2'b10, 4'h5, 4'hF, 0};
      tbl[11] = '{4'h0, 1'b1, 1'b0, 2'b11, 4'h5, 4'hF, 1};
      tbl[12] = '{4'h0, 1'b0, 1'b1, 2'b11, 4'h5, 4'hF, 0};
      tbl[13] = '{4'h0, 1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 1};
      tbl[14] = '{4'h0, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 0};

      repeat (3) tick();
      check("rst_verify", bus.verify, 1);
      check("rst_phase", bus.entry_phase, 0);
      check("rst_d1", bus.user_digit1, 0);
      check("rst_d2", bus.user_digit2, 0);
      check("rst_reject", bus.reject, 0);
      rst_n = 1'b1;
      repeat (3) tick();
      check("post_rst_verify", bus.verify, 1);
      check("post_rst_phase", bus.entry_phase, 0);

      for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("tbl%0d", i));

      for (int k = 0; k < 3; k++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         apply('{a, 1'b1, 1'b0, 2'b01, a, 4'h0, 0}, "rnd_d1");
         apply('{b, 1'b1, 1'b0, 2'b10, a, b, 0}, "rnd_d2");
         apply('{4'h0, 1'b1, 1'b0, 2'b11, a, b, 1}, "rnd_go");
         apply('{4'h0, 1'b1, 1'b0, 2'b00, 4'h0, 4'h0, 1}, "rnd_exit");
      end

      // bounce: short lows of 1..3 cycles, then a stable low of 10 cycles
      s0 = strobes;
      bus.sw = 4'h6;
      lows[0] = 1; lows[1] = 2; lows[2] = 3;
      for (int i = 0; i < 3; i++) begin
         bus.key_enter_n = 1'b0;
         repeat (lows[i]) tick();
         bus.key_enter_n = 1'b1;
         tick();
      end
      exp_q.push_back({2'b01, 4'h6, 4'h0});
      model_obs = {2'b01, 4'h6, 4'h0};
      bus.key_enter_n = 1'b0;
      repeat (6) tick();
      check("bounce_before_phase", bus.entry_phase, 2'b00);
      check("bounce_before_d1", bus.user_digit1, 0);
      tick();
      check("bounce_capture_phase", bus.entry_phase, 2'b01);
      check("bounce_capture_d1", bus.user_digit1, 4'h6);
      repeat (3) tick();
      bus.key_enter_n = 1'b1;
      repeat (12) tick();
      check("bounce_single_phase", bus.entry_phase, 2'b01);
      check("bounce_single_d2", bus.user_digit2, 0);
      check("bounce_strobes", strobes - s0, 0);
      apply('{4'h0, 1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 0}, "bounce_clr");

      // out-of-range digit with MAX_DIGIT = 8
      press_r(4'h9, rej);
      check("rej_pulse", rej, 1);
      check("rej_d1", bus_r.user_digit1, 0);
      check("rej_phase", bus_r.entry_phase, 2'b00);
      press_r(4'h8, rej);
      check("max_ok_pulse", rej, 0);
      check("max_ok_d1", bus_r.user_digit1, 4'h8);
      check("max_ok_phase", bus_r.entry_phase, 2'b01);
      press_r(4'hC, rej);
      check("rej2_pulse", rej, 1);
      check("rej2_d2", bus_r.user_digit2, 0);
      check("rej2_phase", bus_r.entry_phase, 2'b01);

      // reset asserted on the second low cycle of a strobe
      apply('{4'h3, 1'b1, 1'b0, 2'b01, 4'h3, 4'h0, 0}, "rs_d1");
      apply('{4'h9, 1'b1, 1'b0, 2'b10, 4'h3, 4'h9, 0}, "rs_d2");
      s0 = strobes;
      exp_exit = 1'b0;
      exp_q.push_back({2'b11, 4'h3, 4'h9});
      bus.key_enter_n = 1'b0;
      repeat (6) tick();
      check("rs_pre_verify", bus.verify, 1);
      tick();
      check("rs_low1_verify", bus.verify, 0);
      tick();
      check("rs_low2_verify", bus.verify, 0);
      rst_n = 1'b0;
      bus.key_enter_n = 1'b1;
      #1;
      check("rs_async_verify", bus.verify, 1);
      check("rs_async_phase", bus.entry_phase, 0);
      check("rs_async_d1", bus.user_digit1, 0);
      check("rs_async_d2", bus.user_digit2, 0);
      check("rs_async_reject", bus.reject, 0);
      model_obs = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      s0 = strobes;
      rej = 0;
      repeat (20) begin
         tick();
         if (!bus.verify) rej++;
      end
      check("rs_no_resume_low", rej, 0);
      check("rs_no_resume_strobes", strobes - s0, 0);
      check("rs_after_phase", bus.entry_phase, 0);

      check("sb_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
